// File: rtl/spi_bootload_host.sv
// Byte-link command bridge to the SPI bootloader register port.
// Decodes write/read headers, issues single-cycle accesses and returns status/data bytes.
module spi_bootload_host #(
    parameter int unsigned TIMEOUT = 400000000
) (
    input  logic        clk_i,
    input  logic        rst_b_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  adr_o,
    output logic [15:0] dat_o,
    input  logic [15:0] dat_i,
    output logic        en_o,
    output logic        wr_o,
    input  logic        dat_valid_i,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        IDLE,
        GET_HI,
        GET_LO,
        ISSUE,
        WAIT_RD,
        SEND_ACK,
        SEND_ERR,
        SEND_ST,
        SEND_HI,
        SEND_LO
    } state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);
    localparam logic [7:0]  RSP_ACK  = 8'hA5;
    localparam logic [7:0]  RSP_ST   = 8'h5A;
    localparam logic [7:0]  RSP_BAD  = 8'hE1;
    localparam logic [7:0]  RSP_TMO  = 8'hEE;

    state_t      state_q, state_d;
    logic        rx_ready_q, rx_ready_d;
    logic [1:0]  hdr_adr_q, hdr_adr_d;
    logic [7:0]  hi_q, hi_d;
    logic        wr_q, wr_d;
    logic [1:0]  adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] rd_q, rd_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic        rx_fire;
    logic        tx_fire;

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            hdr_adr_q  <= '0;
            hi_q       <= '0;
            wr_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            hdr_adr_q  <= hdr_adr_d;
            hi_q       <= hi_d;
            wr_q       <= wr_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Response byte is a pure function of state so it stays stable under backpressure.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_dat_o   = '0;
        case (state_q)
            SEND_ACK: begin
                tx_valid_o = 1'b1;
                tx_dat_o   = RSP_ACK;
            end
            SEND_ERR: begin
                tx_valid_o = 1'b1;
                tx_dat_o   = tmo_q ? RSP_TMO : RSP_BAD;
            end
            SEND_ST: begin
                tx_valid_o = 1'b1;
                tx_dat_o   = RSP_ST;
            end
            SEND_HI: begin
                tx_valid_o = 1'b1;
                tx_dat_o   = rd_q[15:8];
            end
            SEND_LO: begin
                tx_valid_o = 1'b1;
                tx_dat_o   = rd_q[7:0];
            end
            default: begin
                tx_valid_o = 1'b0;
                tx_dat_o   = '0;
            end
        endcase
    end

    assign rx_fire = rx_valid_i & rx_ready_q;
    assign tx_fire = tx_valid_o & tx_ready_i;

    always_comb begin
        state_d   = state_q;
        hdr_adr_d = hdr_adr_q;
        hi_d      = hi_q;
        wr_d      = wr_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_dat_i[6:2] != 5'd0) begin
                        tmo_d   = 1'b0;
                        state_d = SEND_ERR;
                    end else if (rx_dat_i[7]) begin
                        hdr_adr_d = rx_dat_i[1:0];
                        state_d   = GET_HI;
                    end else begin
                        wr_d    = 1'b0;
                        adr_d   = rx_dat_i[1:0];
                        state_d = ISSUE;
                    end
                end
            end
            GET_HI: begin
                if (rx_fire) begin
                    hi_d    = rx_dat_i;
                    state_d = GET_LO;
                end
            end
            // Access outputs load only on entry to ISSUE so they hold between strobes.
            GET_LO: begin
                if (rx_fire) begin
                    wr_d    = 1'b1;
                    adr_d   = hdr_adr_q;
                    dat_d   = {hi_q, rx_dat_i};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = SEND_ACK;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (dat_valid_i) begin
                    rd_d    = dat_i;
                    state_d = SEND_ST;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = SEND_ERR;
                end
            end
            SEND_ACK, SEND_ERR, SEND_LO: begin
                if (tx_fire) begin
                    state_d = IDLE;
                end
            end
            SEND_ST: begin
                if (tx_fire) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_fire) begin
                    state_d = SEND_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered from next state: low throughout reset, high on the first edge after.
    assign rx_ready_d = (state_d == IDLE) || (state_d == GET_HI) || (state_d == GET_LO);

    assign rx_ready_o = rx_ready_q;
    assign en_o       = (state_q == ISSUE);
    assign wr_o       = wr_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_bootload_host.sv
// Self-checking bench for spi_bootload_host: directed vector table, reset sequences
// and randomized commands scored against a command-level reference model.
module tb_spi_bootload_host;

    localparam int TMO = 100;

    logic        clk_i;
    logic        rst_b_i;
    logic [7:0]  rx_dat_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_dat_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  adr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        en_o;
    logic        wr_o;
    logic        dat_valid_i;
    logic        busy_o;

    spi_bootload_host #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rst_b_i     (rst_b_i),
        .rx_dat_i    (rx_dat_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_dat_o    (tx_dat_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .en_o        (en_o),
        .wr_o        (wr_o),
        .dat_valid_i (dat_valid_i),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]       hdr;
        logic [7:0]       hi;
        logic [7:0]       lo;
        int               lat;
        logic [15:0]      rdat;
        int               stall;
        int               n_en;
        logic             wr;
        logic [1:0]       adr;
        logic [15:0]      dat;
        int               nrsp;
        logic [2:0][7:0]  rsp;
        int               rlat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Monitor / read-data responder state.
    int          cyc = 0;
    int          en_cnt = 0;
    int          en_cyc = 0;
    logic        en_wr = 1'b0;
    logic [1:0]  en_adr = '0;
    logic [15:0] en_dat = '0;
    int          rd_lat = 0;
    logic [15:0] rd_val = '0;
    int          rd_cnt = 0;

    // Reference model memory of the last issued access.
    logic        m_wr = 1'b0;
    logic [1:0]  m_adr = '0;
    logic [15:0] m_dat = '0;
    bit          gaps = 1'b0;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        dat_valid_i = 1'b0;
        dat_i       = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            dat_valid_i = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    dat_valid_i = 1'b1;
                    dat_i       = rd_val;
                end
            end
            if (en_o) begin
                en_cnt++;
                en_cyc = cyc;
                en_wr  = wr_o;
                en_adr = adr_o;
                en_dat = dat_o;
                if (!wr_o && rd_lat > 0) rd_cnt = rd_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] hdr, hi, lo, input int lat,
                                input logic [15:0] rdat, input int stall, input int n_en,
                                input logic wr, input logic [1:0] adr, input logic [15:0] dat,
                                input int nrsp, input logic [7:0] r0, r1, r2, input int rlat);
        vec_t v;
        v.hdr = hdr; v.hi = hi; v.lo = lo; v.lat = lat; v.rdat = rdat; v.stall = stall;
        v.n_en = n_en; v.wr = wr; v.adr = adr; v.dat = dat; v.nrsp = nrsp;
        v.rsp[0] = r0; v.rsp[1] = r1; v.rsp[2] = r2; v.rlat = rlat;
        return v;
    endfunction

    // Command-level model: what the link and register port should see for one command.
    function automatic vec_t model(input logic [7:0] hdr, hi, lo, input int lat,
                                   input logic [15:0] rdat, input int stall);
        vec_t v;
        v = mk(hdr, hi, lo, lat, rdat, stall, 0, m_wr, m_adr, m_dat, 1, 8'h00, 8'h00, 8'h00, -1);
        if (hdr[6:2] != 5'd0) begin
            v.rsp[0] = 8'hE1;
        end else if (hdr[7]) begin
            v.n_en = 1; v.wr = 1'b1; v.adr = hdr[1:0]; v.dat = {hi, lo};
            v.rsp[0] = 8'hA5; v.rlat = 1;
        end else begin
            v.n_en = 1; v.wr = 1'b0; v.adr = hdr[1:0];
            if (lat >= 1 && lat <= TMO) begin
                v.nrsp = 3;
                v.rsp[0] = 8'h5A; v.rsp[1] = rdat[15:8]; v.rsp[2] = rdat[7:0];
                v.rlat = lat + 1;
            end else begin
                v.rsp[0] = 8'hEE; v.rlat = TMO + 1;
            end
        end
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        rx_valid_i = 1'b1;
        rx_dat_i   = b;
        n = 0;
        while (!rx_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("rx_accept", 32'(rx_ready_o), 32'd1);
        tick();
        rx_valid_i = 1'b0;
        rx_dat_i   = 8'($urandom);
    endtask

    task automatic run_cmd(input vec_t v);
        int         en0, first, stall_left, bud;
        logic [7:0] q [$];
        logic       pend;
        logic [7:0] pdat;
        en0    = en_cnt;
        rd_lat = v.lat;
        rd_val = v.rdat;
        send_byte(v.hdr);
        if (v.hdr[7] && v.hdr[6:2] == 5'd0) begin
            send_byte(v.hi);
            send_byte(v.lo);
        end
        first = -1; stall_left = v.stall; pend = 1'b0; pdat = '0; bud = 0;
        while (q.size() < v.nrsp && bud < 400) begin
            if (pend) chk("tx_hold", 32'({tx_valid_o, tx_dat_o}), 32'({1'b1, pdat}));
            if (tx_valid_o) begin
                if (first < 0) first = cyc;
                if (stall_left > 0) begin
                    tx_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready_i = 1'b1;
                end
                if (tx_ready_i) begin
                    q.push_back(tx_dat_o);
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pdat = tx_dat_o;
                end
            end else begin
                tx_ready_i = 1'($urandom_range(0, 1));
            end
            tick();
            bud++;
        end
        tx_ready_i = 1'b0;
        bud = 0;
        while (rd_cnt > 0 && bud < 300) begin
            tick();
            bud++;
        end
        tick();
        tick();
        chk("rsp_count", 32'(q.size()), 32'(v.nrsp));
        for (int i = 0; i < q.size() && i < 3; i++) chk("rsp_byte", 32'(q[i]), 32'(v.rsp[i]));
        chk("en_count", 32'(en_cnt - en0), 32'(v.n_en));
        if (v.n_en > 0) begin
            chk("en_wr", 32'(en_wr), 32'(v.wr));
            chk("en_adr", 32'(en_adr), 32'(v.adr));
            chk("en_dat", 32'(en_dat), 32'(v.dat));
        end
        if (v.rlat >= 0) chk("rsp_latency", 32'(first - en_cyc), 32'(v.rlat));
        chk("hold_wr_adr_dat", 32'({wr_o, adr_o, dat_o}), 32'({v.wr, v.adr, v.dat}));
        chk("idle_after", 32'({busy_o, tx_valid_o, rx_ready_o}), 32'b001);
        m_wr = v.wr; m_adr = v.adr; m_dat = v.dat;
    endtask

    initial begin
        int en0, txv;
        vec_t v;
        logic [7:0] h;

        tbl[0]  = mk(8'h83, 8'h9E, 8'h9E, 0,   16'h0000, 0,  1, 1'b1, 2'd3, 16'h9E9E, 1, 8'hA5, 8'h00, 8'h00, 1);
        tbl[1]  = mk(8'h01, 8'h00, 8'h00, 40,  16'h2018, 0,  1, 1'b0, 2'd1, 16'h9E9E, 3, 8'h5A, 8'h20, 8'h18, 41);
        tbl[2]  = mk(8'h03, 8'h00, 8'h00, 120, 16'h1234, 0,  1, 1'b0, 2'd3, 16'h9E9E, 1, 8'hEE, 8'h00, 8'h00, 101);
        tbl[3]  = mk(8'h7C, 8'h00, 8'h00, 0,   16'h0000, 0,  0, 1'b0, 2'd3, 16'h9E9E, 1, 8'hE1, 8'h00, 8'h00, -1);
        tbl[4]  = mk(8'h80, 8'h11, 8'h22, 0,   16'h0000, 0,  1, 1'b1, 2'd0, 16'h1122, 1, 8'hA5, 8'h00, 8'h00, 1);
        tbl[5]  = mk(8'h02, 8'h00, 8'h00, 100, 16'hABCD, 0,  1, 1'b0, 2'd2, 16'h1122, 3, 8'h5A, 8'hAB, 8'hCD, 101);
        tbl[6]  = mk(8'h00, 8'h00, 8'h00, 1,   16'h0F0F, 0,  1, 1'b0, 2'd0, 16'h1122, 3, 8'h5A, 8'h0F, 8'h0F, 2);
        tbl[7]  = mk(8'h01, 8'h00, 8'h00, 101, 16'h5555, 0,  1, 1'b0, 2'd1, 16'h1122, 1, 8'hEE, 8'h00, 8'h00, 101);
        tbl[8]  = mk(8'h01, 8'h00, 8'h00, 5,   16'hC3E7, 10, 1, 1'b0, 2'd1, 16'h1122, 3, 8'h5A, 8'hC3, 8'hE7, 6);
        tbl[9]  = mk(8'h84, 8'h00, 8'h00, 0,   16'h0000, 0,  0, 1'b0, 2'd1, 16'h1122, 1, 8'hE1, 8'h00, 8'h00, -1);
        tbl[10] = mk(8'h82, 8'h00, 8'hFF, 0,   16'h0000, 3,  1, 1'b1, 2'd2, 16'h00FF, 1, 8'hA5, 8'h00, 8'h00, 1);

        rst_b_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_dat_i   = '0;
        tx_ready_i = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({rx_ready_o, tx_valid_o, tx_dat_o, en_o, wr_o, adr_o, dat_o, busy_o}), 32'd0);
        rst_b_i = 1'b1;
        #1;
        chk("ready_before_edge", 32'(rx_ready_o), 32'd0);
        tick();
        chk("ready_first_edge", 32'(rx_ready_o), 32'd1);

        for (int i = 0; i < 11; i++) run_cmd(tbl[i]);

        // Reset in the middle of a write: header and high byte already taken.
        en0 = en_cnt;
        send_byte(8'h80);
        send_byte(8'h12);
        chk("mid_state_busy", 32'(busy_o), 32'd1);
        rst_b_i = 1'b0;
        #1;
        chk("midrst_outputs", 32'({rx_ready_o, tx_valid_o, tx_dat_o, en_o, wr_o, adr_o, dat_o, busy_o}), 32'd0);
        rx_valid_i = 1'b1;
        rx_dat_i   = 8'h34;
        tick();
        tick();
        rx_valid_i = 1'b0;
        rst_b_i    = 1'b1;
        txv = 0;
        repeat (6) begin
            tick();
            if (tx_valid_o) txv++;
        end
        chk("midrst_no_tx", 32'(txv), 32'd0);
        chk("midrst_no_en", 32'(en_cnt - en0), 32'd0);
        m_wr = 1'b0; m_adr = '0; m_dat = '0;
        run_cmd(model(8'h81, 8'h55, 8'hAA, 0, 16'h0000, 0));

        gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                h = {1'($urandom), 5'($urandom_range(1, 31)), 2'($urandom)};
            end else begin
                h = {1'($urandom), 5'd0, 2'($urandom)};
            end
            v = model(h, 8'($urandom), 8'($urandom), int'($urandom_range(0, 110)),
                      16'($urandom), int'($urandom_range(0, 4)));
            run_cmd(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
